// File: rtl/pulse_spacer_pkg.sv
// Shared types and constants for the pulse spacer.
package pulse_spacer_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StFire,
    StWait
  } state_e;

  localparam int unsigned DropCntW = 16;

endpackage

// File: rtl/sat_updown_cnt.sv
// Saturating up/down counter; flags an increment that is lost at the ceiling.
module sat_updown_cnt #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] value,
  output logic             at_max,
  output logic             drop
);

  localparam logic [CNT_W-1:0] One = CNT_W'(1);

  logic [CNT_W-1:0] value_q, value_d;

  assign at_max = (value_q == '1);
  // A simultaneous decrement frees the slot, so only a lone increment is lost.
  assign drop   = inc & ~dec & at_max;
  assign value  = value_q;

  always_comb begin
    value_d = value_q;
    if (inc && !dec && !at_max) begin
      value_d = value_q + One;
    end else if (dec && !inc && (value_q != '0)) begin
      value_d = value_q - One;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

endmodule

// File: rtl/pulse_spacer.sv
// Queues event pulses and re-emits them at least GAP cycles apart for a pulse synchronizer.
// Optional macro PULSE_SPACER_DROP_CNT_EN adds a saturating dropped-event counter output.
module pulse_spacer
  import pulse_spacer_pkg::*;
#(
  parameter int unsigned GAP   = 4,
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pulse_in,
  input  logic             clr_ovf,
  output logic             pulse_out,
  output logic [CNT_W-1:0] pending,
  output logic             busy,
  output logic             overflow
`ifdef PULSE_SPACER_DROP_CNT_EN
  ,
  output logic [DropCntW-1:0] drop_cnt
`endif
);

  localparam int unsigned      GapW    = $clog2(GAP);
  localparam logic [GapW-1:0]  GapLoad = GapW'(GAP - 3);
  localparam logic [GapW-1:0]  GapOne  = GapW'(1);

  state_e          state_q, state_d;
  logic [GapW-1:0] gap_q, gap_d;
  logic            pulse_q, pulse_d;
  logic            ovf_q, ovf_d;

  logic fire_now;
  logic from_pending;
  logic cnt_inc;
  logic cnt_dec;
  logic cnt_at_max;
  logic cnt_drop;

  // An event launches only from idle; it is taken straight from pulse_in when nothing is queued.
  assign fire_now     = (state_q == StIdle) && ((pending != '0) || pulse_in);
  assign from_pending = fire_now && (pending != '0);
  assign cnt_dec      = from_pending;
  assign cnt_inc      = pulse_in && !(fire_now && !from_pending);

  sat_updown_cnt #(
    .CNT_W (CNT_W)
  ) u_pending (
    .clk    (clk),
    .rst_n  (rst_n),
    .inc    (cnt_inc),
    .dec    (cnt_dec),
    .value  (pending),
    .at_max (cnt_at_max),
    .drop   (cnt_drop)
  );

  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    unique case (state_q)
      StIdle: begin
        if (fire_now) begin
          state_d = StFire;
        end
      end
      StFire: begin
        state_d = StWait;
        gap_d   = GapLoad;
      end
      StWait: begin
        if (gap_q == '0) begin
          state_d = StIdle;
        end else begin
          gap_d = gap_q - GapOne;
        end
      end
      default: begin
        state_d = StIdle;
        gap_d   = '0;
      end
    endcase
    pulse_d = (state_d == StFire);
  end

  always_comb begin
    ovf_d = ovf_q;
    if (cnt_drop) begin
      ovf_d = 1'b1;
    end else if (clr_ovf) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      gap_q   <= '0;
      pulse_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      pulse_q <= pulse_d;
      ovf_q   <= ovf_d;
    end
  end

  assign pulse_out = pulse_q;
  assign overflow  = ovf_q;
  assign busy      = (state_q != StIdle) || (pending != '0);

`ifdef PULSE_SPACER_DROP_CNT_EN
  logic [DropCntW-1:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (cnt_drop) begin
      if (drop_cnt_q != '1) begin
        drop_cnt_d = drop_cnt_q + DropCntW'(1);
      end
    end else if (clr_ovf) begin
      drop_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign drop_cnt = drop_cnt_q;
`else
  logic unused_at_max;
  assign unused_at_max = cnt_at_max;
`endif

endmodule
